// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: outstanding-fetch address, valid/accept request, flush/branch/sequential selection.
// Define PC_FETCH_CNT_EN to add the fetch_cnt accepted-fetch counter output.
module pc_fetch_gen #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          INC          = 4,
  parameter int          ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             inst_addr_ok,
  output logic             inst_req,
  output logic [WIDTH-1:0] pc,
  output logic             adel
`ifdef PC_FETCH_CNT_EN
  ,
  output logic [31:0]      fetch_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, PEND, ERR} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             adel_q, adel_d;
  logic             accept;

  // Loop form keeps ALIGN_BITS == 0 legal (check disabled).
  function automatic logic misaligned(input logic [WIDTH-1:0] a);
    logic m;
    m = 1'b0;
    for (int i = 0; i < ALIGN_BITS; i++) m = m | a[i];
    return m;
  endfunction

  assign inst_req = ((state_q == RUN) || (state_q == PEND)) && !stall && !flush;
  assign accept   = inst_req && inst_addr_ok;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    if (flush) begin
      pc_d         = flush_target;
      pend_valid_d = 1'b0;
      state_d      = misaligned(flush_target) ? ERR : RUN;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          // The current pc is the delay slot; the redirect waits for its accept.
          if (branch_taken && !accept) begin
            pend_target_d = branch_target;
            pend_valid_d  = 1'b1;
            state_d       = PEND;
          end else if (accept) begin
            pc_d    = branch_taken ? branch_target : pc_q + WIDTH'(INC);
            state_d = misaligned(pc_d) ? ERR : RUN;
          end
        end
        PEND: begin
          if (accept) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            state_d      = misaligned(pend_target_q) ? ERR : RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
    adel_d = misaligned(pc_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= WIDTH'(RESET_VECTOR);
      pend_valid_q <= 1'b0;
      adel_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      adel_q       <= adel_d;
    end
    pend_target_q <= pend_target_d;
  end

  assign pc   = pc_q;
  assign adel = adel_q;

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  assign fetch_cnt_d = accept ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) fetch_cnt_q <= 32'd0;
    else     fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed vector bench for pc_fetch_gen: 32-bit default instance plus an 8-bit wrap-around instance.
module tb_pc_fetch_gen;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] ftgt;
    logic        br;
    logic [31:0] btgt;
    logic        ok;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_adel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, inst_addr_ok;
  logic [31:0] flush_target, branch_target;
  logic        inst_req, adel;
  logic [31:0] pc;
  logic        rst8, ok8, req8, adel8;
  logic [7:0]  pc8;
  logic [7:0]  zero8;
`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt, fetch_cnt8;
  int          exp_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[25];

  always #5 clk = ~clk;

  pc_fetch_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_target(flush_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .inst_addr_ok(inst_addr_ok),
    .inst_req(inst_req), .pc(pc), .adel(adel)
`ifdef PC_FETCH_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  pc_fetch_gen #(.WIDTH(8), .RESET_VECTOR(32'h000000FC), .INC(4), .ALIGN_BITS(2)) dut8 (
    .clk(clk), .rst(rst8), .stall(1'b0), .flush(1'b0), .flush_target(zero8),
    .branch_taken(1'b0), .branch_target(zero8), .inst_addr_ok(ok8),
    .inst_req(req8), .pc(pc8), .adel(adel8)
`ifdef PC_FETCH_CNT_EN
    , .fetch_cnt(fetch_cnt8)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic [31:0] ft,
                              input logic b, input logic [31:0] bt, input logic ok,
                              input logic er, input logic [31:0] ep, input logic ea);
    vec_t v;
    v.stall = s; v.flush = f; v.ftgt = ft; v.br = b; v.btgt = bt; v.ok = ok;
    v.exp_req = er; v.exp_pc = ep; v.exp_adel = ea;
    return v;
  endfunction

  // Called at posedge+1: drive, check the request, then check state after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    stall = v.stall; flush = v.flush; flush_target = v.ftgt;
    branch_taken = v.br; branch_target = v.btgt; inst_addr_ok = v.ok;
    #1;
    chk($sformatf("v%0d_req", idx), {31'd0, inst_req}, {31'd0, v.exp_req});
`ifdef PC_FETCH_CNT_EN
    if (v.exp_req && v.ok) exp_cnt++;
`endif
    @(posedge clk); #1;
    chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d_adel", idx), {31'd0, adel}, {31'd0, v.exp_adel});
  endtask

  initial begin
    //          stall flush ftgt          br  btgt          ok req pc            adel
    vecs[0]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 0, 32'hBFC00000, 0);
    vecs[1]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00004, 0);
    vecs[2]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00008, 0);
    vecs[3]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC0000C, 0);
    vecs[4]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00010, 0);
    vecs[5]  = mk(0, 0, 32'h0,          1, 32'hBFC00100,   0, 1, 32'hBFC00010, 0);
    vecs[6]  = mk(0, 0, 32'h0,          1, 32'hBFC00200,   0, 1, 32'hBFC00010, 0);
    vecs[7]  = mk(0, 0, 32'h0,          0, 32'h0,          0, 1, 32'hBFC00010, 0);
    vecs[8]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00100, 0);
    vecs[9]  = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00104, 0);
    vecs[10] = mk(1, 0, 32'h0,          1, 32'hBFC00300,   1, 0, 32'hBFC00104, 0);
    vecs[11] = mk(1, 0, 32'h0,          0, 32'h0,          1, 0, 32'hBFC00104, 0);
    vecs[12] = mk(1, 1, 32'hBFC00380,   0, 32'h0,          1, 0, 32'hBFC00380, 0);
    vecs[13] = mk(1, 0, 32'h0,          0, 32'h0,          1, 0, 32'hBFC00380, 0);
    vecs[14] = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00384, 0);
    vecs[15] = mk(0, 0, 32'h0,          1, 32'hBFC00102,   1, 1, 32'hBFC00102, 1);
    vecs[16] = mk(0, 0, 32'h0,          0, 32'h0,          1, 0, 32'hBFC00102, 1);
    vecs[17] = mk(0, 0, 32'h0,          1, 32'hBFC00200,   1, 0, 32'hBFC00102, 1);
    vecs[18] = mk(0, 1, 32'hBFC00380,   0, 32'h0,          1, 0, 32'hBFC00380, 0);
    vecs[19] = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00384, 0);
    vecs[20] = mk(1, 0, 32'h0,          0, 32'h0,          1, 0, 32'hBFC00384, 0);
    vecs[21] = mk(0, 1, 32'hBFC00381,   0, 32'h0,          1, 0, 32'hBFC00381, 1);
    vecs[22] = mk(0, 0, 32'h0,          0, 32'h0,          1, 0, 32'hBFC00381, 1);
    vecs[23] = mk(0, 1, 32'hBFC00000,   0, 32'h0,          1, 0, 32'hBFC00000, 0);
    vecs[24] = mk(0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hBFC00004, 0);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; inst_addr_ok = 1'b1;
    flush_target = 32'h0; branch_target = 32'h0;
    rst8 = 1'b1; ok8 = 1'b1; zero8 = 8'h00;
`ifdef PC_FETCH_CNT_EN
    exp_cnt = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'hBFC00000);
    chk("reset_req", {31'd0, inst_req}, 32'd0);
    chk("reset_adel", {31'd0, adel}, 32'd0);
`ifdef PC_FETCH_CNT_EN
    chk("reset_cnt", fetch_cnt, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 25; i++) run_vec(vecs[i], i);
`ifdef PC_FETCH_CNT_EN
    chk("cnt_after_vecs", fetch_cnt, 32'(exp_cnt));
`endif

    // Reset while a redirect is pending discards it.
    run_vec(mk(0, 0, 32'h0, 1, 32'hBFC00500, 0, 1, 32'hBFC00004, 0), 25);
    rst = 1'b1; inst_addr_ok = 1'b1; branch_taken = 1'b0;
    @(posedge clk); #1;
    chk("pend_rst_pc", pc, 32'hBFC00000);
    chk("pend_rst_req", {31'd0, inst_req}, 32'd0);
`ifdef PC_FETCH_CNT_EN
    chk("pend_rst_cnt", fetch_cnt, 32'd0);
`endif
    rst = 1'b0;
    run_vec(mk(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'hBFC00000, 0), 26);
    run_vec(mk(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'hBFC00004, 0), 27);

    // 8-bit instance wraps FC -> 00 -> 04.
    rst8 = 1'b0;
    #1;
    chk("w8_boot_req", {31'd0, req8}, 32'd0);
    @(posedge clk); #1;
    chk("w8_pc0", {24'd0, pc8}, 32'h000000FC);
    chk("w8_run_req", {31'd0, req8}, 32'd1);
    @(posedge clk); #1;
    chk("w8_pc1", {24'd0, pc8}, 32'h00000000);
    chk("w8_adel", {31'd0, adel8}, 32'd0);
    @(posedge clk); #1;
    chk("w8_pc2", {24'd0, pc8}, 32'h00000004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
